// File: rtl/spi_xmit_queue_if.sv
// Bundle of the push-side command bus and the SPI-master-facing outputs of spi_xmit_queue.
// The slave modport is the queue itself; the master modport is whoever pushes and observes it.
interface spi_xmit_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          Wr_i;
    logic [7:0]    WrData_i;
    logic [1:0]    WrSs_i;
    logic          Flush_i;
    logic          ClrErr_i;
    logic [7:0]    Buf_o;
    logic [1:0]    ss_o;
    logic          Strobe_o;
    logic          Busy_o;
    logic          Full_o;
    logic          Empty_o;
    logic [CW-1:0] Count_o;
    logic          Ovf_o;
    logic          SsErr_o;

    modport slave (
        input  Wr_i, WrData_i, WrSs_i, Flush_i, ClrErr_i,
        output Buf_o, ss_o, Strobe_o, Busy_o, Full_o, Empty_o, Count_o, Ovf_o, SsErr_o
    );

    modport master (
        output Wr_i, WrData_i, WrSs_i, Flush_i, ClrErr_i,
        input  Buf_o, ss_o, Strobe_o, Busy_o, Full_o, Empty_o, Count_o, Ovf_o, SsErr_o
    );
endinterface

// File: rtl/spi_xmit_queue.sv
// FIFO of (byte, slave-select) commands feeding an SPI master that has no busy/done output;
// each entry is presented, strobed once, then followed by a fixed gap covering one 8-bit transfer.
module spi_xmit_queue #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 50
) (
    input  logic           Clk_i,
    input  logic           Rst_i,
    spi_xmit_queue_if.slave q_if
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      buf_q;
    logic [1:0]      ss_q;
    logic            strobe_q, strobe_d;
    logic            ovf_q, ovf_d;
    logic            sserr_q, sserr_d;

    logic [9:0]      mem [DEPTH];

    logic            full;
    logic            empty;
    logic            ss_ok;
    logic            accept;
    logic            pop;

    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign ss_ok  = (q_if.WrSs_i == 2'b01) || (q_if.WrSs_i == 2'b10);
    assign accept = q_if.Wr_i && !full && ss_ok && !q_if.Flush_i;

    // Pacing FSM: one pop per pass, strobe one cycle after the data settles.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        strobe_d = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                strobe_d = 1'b1;
                state_d  = STROBE;
            end
            STROBE: begin
                gap_d   = GW'(GAP_CYCLES - 1);
                state_d = GAP;
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flush clears occupancy but leaves the entry already popped into buf_q/ss_q alone.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (q_if.Flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(accept) - CW'(pop);
        end
    end

    always_comb begin
        ovf_d   = (ovf_q   && !q_if.ClrErr_i) || (q_if.Wr_i && full);
        sserr_d = (sserr_q && !q_if.ClrErr_i) || (q_if.Wr_i && !ss_ok);
    end

    always_ff @(posedge Clk_i) begin
        if (accept) begin
            mem[wr_ptr_q] <= {q_if.WrSs_i, q_if.WrData_i};
        end
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state_q  <= IDLE;
            gap_q    <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            buf_q    <= '0;
            ss_q     <= '0;
            strobe_q <= 1'b0;
            ovf_q    <= 1'b0;
            sserr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            strobe_q <= strobe_d;
            ovf_q    <= ovf_d;
            sserr_q  <= sserr_d;
            if (pop) begin
                buf_q <= mem[rd_ptr_q][7:0];
                ss_q  <= mem[rd_ptr_q][9:8];
            end
        end
    end

    assign q_if.Buf_o    = buf_q;
    assign q_if.ss_o     = ss_q;
    assign q_if.Strobe_o = strobe_q;
    assign q_if.Busy_o   = (state_q != IDLE);
    assign q_if.Full_o   = full;
    assign q_if.Empty_o  = empty;
    assign q_if.Count_o  = count_q;
    assign q_if.Ovf_o    = ovf_q;
    assign q_if.SsErr_o  = sserr_q;
endmodule

// File: tb/tb_spi_xmit_queue.sv
// Directed bench for spi_xmit_queue: expected strobed entries go into a scoreboard queue that a
// negedge monitor drains on every Strobe_o; the main thread checks flags, counts and timing.
module tb_spi_xmit_queue;
    localparam int DEPTH = 8;
    localparam int GAP   = 50;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_xmit_queue_if #(.DEPTH(DEPTH)) q_if ();

    spi_xmit_queue #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .Clk_i (clk),
        .Rst_i (rst),
        .q_if  (q_if)
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [9:0] exp_q[$];
    int         stb_cyc[$];
    logic       prev_stb = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must carry the next expected (ss, byte) pair.
    always @(negedge clk) begin
        if (rst) begin
            prev_stb = 1'b0;
        end else begin
            if (q_if.Strobe_o) begin
                stb_cyc.push_back(cyc);
                chk("strobe_single_cycle", {31'd0, prev_stb}, 32'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got ss=%b buf=%h want none", q_if.ss_o, q_if.Buf_o);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    chk("strobe_data", {22'd0, q_if.ss_o, q_if.Buf_o}, {22'd0, e});
                    $display("strobe cyc=%0d ss=%b buf=%h", cyc, q_if.ss_o, q_if.Buf_o);
                end
            end
            prev_stb = q_if.Strobe_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d, input logic [1:0] s);
        q_if.Wr_i     = 1'b1;
        q_if.WrData_i = d;
        q_if.WrSs_i   = s;
        tick();
        q_if.Wr_i     = 1'b0;
        $display("write data=%h ss=%b -> count=%0d", d, s, q_if.Count_o);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while ((q_if.Busy_o || !q_if.Empty_o) && n < limit) begin
            tick();
            n++;
        end
        chk(name, {31'd0, (n < limit)}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_buf"},    {24'd0, q_if.Buf_o}, 32'd0);
        chk({tag, "_ss"},     {30'd0, q_if.ss_o}, 32'd0);
        chk({tag, "_strobe"}, {31'd0, q_if.Strobe_o}, 32'd0);
        chk({tag, "_busy"},   {31'd0, q_if.Busy_o}, 32'd0);
        chk({tag, "_empty"},  {31'd0, q_if.Empty_o}, 32'd1);
        chk({tag, "_full"},   {31'd0, q_if.Full_o}, 32'd0);
        chk({tag, "_count"},  {28'd0, q_if.Count_o}, 32'd0);
        chk({tag, "_ovf"},    {31'd0, q_if.Ovf_o}, 32'd0);
        chk({tag, "_sserr"},  {31'd0, q_if.SsErr_o}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        q_if.Wr_i     = 1'b0;
        q_if.WrData_i = 8'h00;
        q_if.WrSs_i   = 2'b00;
        q_if.Flush_i  = 1'b0;
        q_if.ClrErr_i = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Single entry: latency, strobe width, busy duration.
        exp_q.push_back({2'b01, 8'hA5});
        do_write(8'hA5, 2'b01);
        chk("single_count1", {28'd0, q_if.Count_o}, 32'd1);
        chk("single_busy_pre", {31'd0, q_if.Busy_o}, 32'd0);
        tick();
        chk("single_buf", {24'd0, q_if.Buf_o}, 32'hA5);
        chk("single_ss", {30'd0, q_if.ss_o}, 32'h1);
        chk("single_busy", {31'd0, q_if.Busy_o}, 32'd1);
        chk("single_strobe_early", {31'd0, q_if.Strobe_o}, 32'd0);
        chk("single_count0", {28'd0, q_if.Count_o}, 32'd0);
        tick();
        chk("single_strobe_hi", {31'd0, q_if.Strobe_o}, 32'd1);
        tick();
        chk("single_strobe_lo", {31'd0, q_if.Strobe_o}, 32'd0);
        repeat (49) tick();
        chk("single_busy_end_minus1", {31'd0, q_if.Busy_o}, 32'd1);
        tick();
        chk("single_busy_end", {31'd0, q_if.Busy_o}, 32'd0);
        chk("single_buf_hold", {24'd0, q_if.Buf_o}, 32'hA5);

        // Burst of 10: the first pop frees a slot, so entries 0..8 fit and entry 9 overflows.
        stb_cyc.delete();
        for (int k = 0; k < 10; k++) begin
            logic [1:0] s;
            s = (k % 2 == 1) ? 2'b10 : 2'b01;
            if (k <= 8) exp_q.push_back({s, 8'(k)});
            do_write(8'(k), s);
        end
        chk("burst_count", {28'd0, q_if.Count_o}, 32'd8);
        chk("burst_full", {31'd0, q_if.Full_o}, 32'd1);
        chk("burst_ovf", {31'd0, q_if.Ovf_o}, 32'd1);
        chk("burst_sserr", {31'd0, q_if.SsErr_o}, 32'd0);
        wait_idle("burst_drain", 800);
        chk("burst_nstrobes", stb_cyc.size(), 32'd9);
        for (int i = 1; i < stb_cyc.size(); i++)
            chk("burst_spacing", stb_cyc[i] - stb_cyc[i-1], 32'd53);
        chk("burst_ovf_sticky", {31'd0, q_if.Ovf_o}, 32'd1);
        q_if.ClrErr_i = 1'b1;
        tick();
        q_if.ClrErr_i = 1'b0;
        chk("burst_ovf_clr", {31'd0, q_if.Ovf_o}, 32'd0);

        // Illegal slave-select masks are dropped and flagged.
        stb_cyc.delete();
        do_write(8'h11, 2'b11);
        chk("sserr_count_11", {28'd0, q_if.Count_o}, 32'd0);
        chk("sserr_flag_11", {31'd0, q_if.SsErr_o}, 32'd1);
        do_write(8'h22, 2'b00);
        chk("sserr_count_00", {28'd0, q_if.Count_o}, 32'd0);
        q_if.ClrErr_i = 1'b1;
        do_write(8'h33, 2'b00);
        q_if.ClrErr_i = 1'b0;
        chk("sserr_new_err_wins", {31'd0, q_if.SsErr_o}, 32'd1);
        q_if.ClrErr_i = 1'b1;
        tick();
        q_if.ClrErr_i = 1'b0;
        chk("sserr_clr", {31'd0, q_if.SsErr_o}, 32'd0);
        repeat (5) tick();
        chk("sserr_no_strobe", stb_cyc.size(), 32'd0);
        chk("sserr_idle", {31'd0, q_if.Busy_o}, 32'd0);

        // Flush during the first entry's gap: in-flight entry still completes alone.
        stb_cyc.delete();
        exp_q.push_back({2'b01, 8'h71});
        do_write(8'h71, 2'b01);
        do_write(8'h72, 2'b10);
        do_write(8'h73, 2'b01);
        chk("flush_preload_count", {28'd0, q_if.Count_o}, 32'd2);
        tick();
        tick();
        q_if.Flush_i = 1'b1;
        tick();
        q_if.Flush_i = 1'b0;
        chk("flush_count", {28'd0, q_if.Count_o}, 32'd0);
        chk("flush_empty", {31'd0, q_if.Empty_o}, 32'd1);
        chk("flush_busy", {31'd0, q_if.Busy_o}, 32'd1);
        chk("flush_buf_hold", {24'd0, q_if.Buf_o}, 32'h71);
        wait_idle("flush_drain", 200);
        chk("flush_nstrobes", stb_cyc.size(), 32'd1);

        // Asynchronous reset while Strobe_o is high.
        do_write(8'h5A, 2'b10);
        tick();
        tick();
        chk("arst_strobe_before", {31'd0, q_if.Strobe_o}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs("arst");
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back({2'b01, 8'hA5});
        do_write(8'hA5, 2'b01);
        tick();
        chk("arst_after_buf", {24'd0, q_if.Buf_o}, 32'hA5);
        chk("arst_after_ss", {30'd0, q_if.ss_o}, 32'h1);
        tick();
        chk("arst_after_strobe", {31'd0, q_if.Strobe_o}, 32'd1);
        wait_idle("arst_after_drain", 200);

        // Steady occupancy of 4 with write+pop on the same edge; 20 entries wrap the pointers.
        stb_cyc.delete();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({(i % 2 == 1) ? 2'b10 : 2'b01, 8'(8'h40 + i)});
            do_write(8'(8'h40 + i), (i % 2 == 1) ? 2'b10 : 2'b01);
        end
        chk("wrap_count_init", {28'd0, q_if.Count_o}, 32'd4);
        for (int i = 5; i < 20; i++) begin
            int n;
            n = 0;
            while (q_if.Busy_o && n < 100) begin
                tick();
                n++;
            end
            chk("wrap_wait_idle", {31'd0, (n < 100)}, 32'd1);
            chk("wrap_count_before", {28'd0, q_if.Count_o}, 32'd4);
            exp_q.push_back({(i % 2 == 1) ? 2'b10 : 2'b01, 8'(8'h40 + i)});
            do_write(8'(8'h40 + i), (i % 2 == 1) ? 2'b10 : 2'b01);
            chk("wrap_count_wr_pop", {28'd0, q_if.Count_o}, 32'd4);
            chk("wrap_busy", {31'd0, q_if.Busy_o}, 32'd1);
        end
        wait_idle("wrap_drain", 600);
        chk("wrap_nstrobes", stb_cyc.size(), 32'd20);
        for (int i = 1; i < stb_cyc.size(); i++)
            chk("wrap_spacing", stb_cyc[i] - stb_cyc[i-1], 32'd53);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_xmit_queue.md
Name: spi_xmit_queue

Overview:
- Buffered command stage directly upstream of the SPI master.
- Software or other logic pushes (byte, slave-select) pairs into a FIFO.
- The block pops one entry at a time and presents it on the master's Buf_i and ss_i inputs, then pulses the master's Strobe_i.
- The master has no done/busy output, so pacing uses a fixed gap counter sized to cover one full 8-bit transfer.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, ≥2.
- GAP_CYCLES, 50, idle Clk_i cycles after the strobe before the next entry may load; ≥1.
- CW, $clog2(DEPTH)+1, width of Count_o (derived, not overridden).

Ports:
- Clk_i  in  1  system clock; all state updates on rising edge.
- Rst_i  in  1  asynchronous, active-high reset.
- Wr_i  in  1  push request; one entry per cycle while high.
- WrData_i  in  8  byte to transmit.
- WrSs_i  in  2  slave-select mask for this byte; must be one-hot.
- Flush_i  in  1  synchronous clear of FIFO contents.
- ClrErr_i  in  1  synchronous clear of the sticky error flags.
- Buf_o  out  8  to master Buf_i.
- ss_o  out  2  to master ss_i.
- Strobe_o  out  1  to master Strobe_i; single-cycle pulse.
- Busy_o  out  1  high in any state other than IDLE.
- Full_o  out  1  Count_o == DEPTH.
- Empty_o  out  1  Count_o == 0.
- Count_o  out  CW  current occupancy.
- Ovf_o  out  1  sticky: a write was dropped because the FIFO was full.
- SsErr_o  out  1  sticky: a write was dropped because WrSs_i was not one-hot.

Behaviour:
- Reset (async, takes effect immediately):
  - Count = 0, pointers = 0, state = IDLE.
  - Buf_o = 0, ss_o = 0, Strobe_o = 0.
  - Ovf_o = 0, SsErr_o = 0, Busy_o = 0, Empty_o = 1, Full_o = 0.
  - A reset mid-transfer drops Strobe_o in the same instant and discards all entries.
- All outputs are registered; Full_o, Empty_o and Busy_o are decoded from registered state.
- Write acceptance: an entry is accepted when Wr_i=1, Full_o=0, WrSs_i is 01 or 10, and Flush_i=0.
  - Wr_i with Full_o=1: drop the entry, set Ovf_o. This applies even if a pop occurs in the same cycle.
  - Wr_i with WrSs_i of 00 or 11: drop the entry, set SsErr_o.
- Pop and write in the same cycle: Count_o unchanged; the pointers wrap modulo DEPTH.
- Flush_i: sets Count = 0 and pointers = 0 on the next edge; it has priority over a simultaneous write.
  - Flush does not abort an in-flight entry; Buf_o, ss_o, state and the counter are unaffected.
- ClrErr_i clears both sticky flags. A new error in the same cycle wins, so the flag stays 1.
- State machine:
  - IDLE:
    - Empty: stay.
    - Not empty: pop the head into Buf_o/ss_o and go to SETUP.
  - SETUP: data stable for one cycle. Next edge: Strobe_o = 1, go to STROBE.
  - STROBE: next edge: Strobe_o = 0, gap counter = GAP_CYCLES-1, go to GAP.
  - GAP:
    - Counter ≠ 0: decrement.
    - Counter = 0: go to IDLE.
    - Buf_o and ss_o hold their values throughout GAP and IDLE until the next pop.
- Timing with a continuously non-empty FIFO: rising edges of Strobe_o are spaced GAP_CYCLES+3 cycles apart.
- Latency: a write into an empty, idle queue at edge N gives:
  - Count_o = 1 at edge N+1;
  - pop and Buf_o valid at edge N+2;
  - Strobe_o high from edge N+3 to edge N+4.
- Strobe_o is never high for more than one cycle. It is only asserted with ss_o one-hot and Buf_o stable for at least one prior cycle.
- Count_o never exceeds DEPTH and never underflows.

Test Plan:
- Reset, then write (8'hA5, 2'b01) once → Buf_o = A5 and ss_o = 01 two cycles after the write. Strobe_o is high for exactly one cycle one cycle later. Busy_o returns to 0 after GAP_CYCLES+3 cycles. The slave with ID 0 receives A5.
- Burst of 10 writes (8'h00..8'h09, ss alternating 01/10) with DEPTH=8 → entries 0..7 are accepted, or 0..8 if the pop happens before the last write. Dropped writes set Ovf_o=1. Strobe rising edges are spaced exactly 53 cycles apart. Bytes come out in order.
- Write with WrSs_i = 2'b11, then 2'b00 → Count_o stays 0 and SsErr_o = 1. ClrErr_i clears it. No strobe is issued.
- Pre-load 3 entries, assert Flush_i during the first entry's GAP → Count_o = 0 on the next edge. The in-flight transfer completes, with one strobe total.
- Assert Rst_i asynchronously while in STROBE → Strobe_o falls without waiting for a clock edge. All outputs take their reset values. Stimulus after reset behaves as in the first scenario.
- Simultaneous write and pop at Count_o = 4 → Count_o stays 4. The pointer wrap across the DEPTH boundary preserves data order over 20 sequential entries.
